obi_pulser: RTL and testbench
=============================

# obi_pulser

OBI subordinate peripheral generating a programmable pulse train on one output pin. It sits behind the peripheral demux at offset 0x0300_C000 (4 KiB window) and answers sbr_obi_req_t requests with sbr_obi_rsp_t responses (32-bit data, 32-bit address, subordinate ID width). Software programs period, high time and pulse count, then enables it. An optional done interrupt reports completion of a finite burst.

## Interface
- CntWidth, 32: width of the PERIOD/HIGH/COUNT registers and internal counters (max 32).
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- obi_req_i  in  sbr_obi_req_t  OBI request (a.addr, a.we, a.be, a.wdata, a.aid, req).
- obi_rsp_o  out  sbr_obi_rsp_t  OBI response (gnt, rvalid, r.rdata, r.rid, r.err; r_optional=0).
- pulse_o  out  1  pulse output.
- irq_o  out  1  done interrupt, level.

## Operation
- Register map (decoded on a.addr[11:2], word-aligned):
  - 0x00 CTRL RW: [0] EN, [1] ONESHOT, [2] INV; other bits read 0.
  - 0x04 PERIOD RW: cycles per period; 0 treated as 1.
  - 0x08 HIGH RW: high cycles per period.
  - 0x0C COUNT RW: pulses per burst; 0 = infinite.
  - 0x10 STATUS: [0] BUSY RO, [1] DONE W1C.
  - 0x14 CNT RO: current cycle counter.
  - Any other offset: err=1, rdata=0, no state change.
- Writes honour a.be per byte; bytes with be=0 unchanged. Writes to RO fields ignored, no error.
- FSM states IDLE, RUN, DONE:
  - IDLE: cnt=0, pulses=0. EN=1 observed -> RUN next cycle.
  - RUN: cnt increments each cycle; at cnt==max(PERIOD,1)-1, cnt->0 and pulses increments. If COUNT!=0 and the wrapping period is pulse number COUNT -> DONE, DONE bit set.
  - DONE: output idle. If ONESHOT=1, hardware clears EN on entry. EN written 0 -> IDLE. EN still 1 with ONESHOT=0 -> stays DONE until EN cleared.
  - EN written 0 in any state -> IDLE next cycle, cnt/pulses cleared; DONE bit preserved.
- pulse_o (raw) = RUN && (cnt < HIGH); INV=1 inverts it in all states (idle level = INV).
- HIGH=0 -> raw constantly 0; HIGH>=PERIOD -> constantly 1 during RUN.
- PERIOD/HIGH/COUNT writes during RUN take effect immediately; if new PERIOD <= cnt, counter wraps at next cycle (compare uses cnt >= PERIOD-1).
- Counters are CntWidth unsigned; pulses counter saturates, never wraps.
- Simultaneous W1C of DONE and hardware DONE set: set wins.

## Timing
- gnt = req, combinational, every cycle; no backpressure.
- rvalid exactly one cycle after a granted request; rid = registered a.aid; rdata/err registered with it. Back-to-back requests every cycle supported.
- Register writes visible to the FSM the cycle after grant; first RUN cycle has cnt=0 with pulse_o high if HIGH>0.
- pulse_o registered; changes one cycle after the FSM state/cnt driving it.
- Reset values: all registers 0, FSM IDLE, rvalid=0, rdata=0, rid=0, err=0, pulse_o=0, irq_o=0. Reset mid-response drops the pending rvalid.

## Configuration
- OBI_PULSER_IRQ_EN defined: irq_o = DONE bit, high from the cycle after DONE is set until W1C clears it.
- Not defined: irq_o tied 0; DONE bit in STATUS still functional for polling.

## Test plan
- Reset, then read 0x00..0x14 -> all rdata=0, err=0, rvalid one cycle after each gnt, rid echoes aid.
- PERIOD=4, HIGH=1, COUNT=3, CTRL=0x1 -> pulse_o high 1 of every 4 cycles, 3 pulses, then DONE; STATUS reads 0x2; irq_o=1 (with macro).
- PERIOD=5, HIGH=2, COUNT=0, INV=1, EN=1 -> pulse_o low 2/high 3 repeating; write CTRL=0x4 mid-period -> pulse_o high (idle, inverted) next cycles, CNT reads 0.
- ONESHOT=1, COUNT=2 -> after DONE, CTRL reads 0x2 (EN cleared); write STATUS=0x2 -> DONE=0, irq_o=0.
- Write 0xAABBCCDD to PERIOD with be=0b0101 over 0 -> reads 0x00BB00DD; read offset 0x40 -> err=1, rdata=0.
- Edge cases: HIGH=0 -> pulse_o stays 0; HIGH=8 with PERIOD=4 -> constant 1 in RUN; PERIOD=0 -> behaves as 1.

Source files
------------

// File: rtl/obi_pulser.sv
// OBI subordinate pulse-train generator: PERIOD/HIGH/COUNT registers drive an IDLE/RUN/DONE FSM.
// Define OBI_PULSER_IRQ_EN to route the sticky DONE bit to irq_o; otherwise irq_o is tied low.
package obi_pulser_pkg;
   localparam int unsigned SbrIdWidth = 4;

   typedef struct packed {
      logic [31:0]           addr;
      logic                  we;
      logic [3:0]            be;
      logic [31:0]           wdata;
      logic [SbrIdWidth-1:0] aid;
   } sbr_obi_a_chan_t;

   typedef struct packed {
      sbr_obi_a_chan_t a;
      logic            req;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0]           rdata;
      logic [SbrIdWidth-1:0] rid;
      logic                  err;
      logic                  r_optional;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      sbr_obi_r_chan_t r;
   } sbr_obi_rsp_t;
endpackage

module obi_pulser
   import obi_pulser_pkg::*;
#(
   parameter int unsigned CntWidth = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  sbr_obi_req_t obi_req_i,
   output sbr_obi_rsp_t obi_rsp_o,
   output logic         pulse_o,
   output logic         irq_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                state_q, state_d;
   logic [2:0]            ctrl_q, ctrl_d;
   logic [CntWidth-1:0]   period_q, period_d, high_q, high_d, count_q, count_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d, pulses_q, pulses_d;
   logic                  done_q, done_d, pulse_q, pulse_d;
   logic                  rvalid_q, rvalid_d, err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [SbrIdWidth-1:0] rid_q, rid_d;

   logic [9:0]            idx;
   logic                  wr, rd, addr_ok, done_set, done_clr, wrap;
   logic [31:0]           cur, merged;
   logic [CntWidth-1:0]   period_eff;
   logic [CntWidth:0]     pulses_nxt;
   logic                  unused_addr;

   assign unused_addr = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0]};

   function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

   always_comb begin
      idx     = obi_req_i.a.addr[11:2];
      wr      = obi_req_i.req & obi_req_i.a.we;
      rd      = obi_req_i.req & ~obi_req_i.a.we;
      addr_ok = (idx <= 10'd5);

      case (idx)
         10'd0:   cur = {29'b0, ctrl_q};
         10'd1:   cur = 32'(period_q);
         10'd2:   cur = 32'(high_q);
         10'd3:   cur = 32'(count_q);
         10'd4:   cur = {30'b0, done_q, state_q == RUN};
         10'd5:   cur = 32'(cnt_q);
         default: cur = 32'b0;
      endcase
      merged = be_merge(cur, obi_req_i.a.wdata, obi_req_i.a.be);

      rvalid_d = obi_req_i.req;
      rid_d    = obi_req_i.req ? obi_req_i.a.aid : '0;
      err_d    = obi_req_i.req & ~addr_ok;
      rdata_d  = (rd & addr_ok) ? cur : 32'b0;

      ctrl_d   = ctrl_q;
      period_d = period_q;
      high_d   = high_q;
      count_d  = count_q;
      done_clr = 1'b0;
      if (wr) begin
         case (idx)
            10'd0:   ctrl_d   = merged[2:0];
            10'd1:   period_d = merged[CntWidth-1:0];
            10'd2:   high_d   = merged[CntWidth-1:0];
            10'd3:   count_d  = merged[CntWidth-1:0];
            10'd4:   done_clr = obi_req_i.a.be[0] & obi_req_i.a.wdata[1];
            default: ;
         endcase
      end

      // Compare with >= so a PERIOD shrunk below the live count wraps at once.
      period_eff = (period_q == '0) ? CntWidth'(1) : period_q;
      wrap       = (cnt_q >= period_eff - CntWidth'(1));
      pulses_nxt = {1'b0, pulses_q} + (CntWidth+1)'(1);

      state_d  = state_q;
      cnt_d    = cnt_q;
      pulses_d = pulses_q;
      done_set = 1'b0;
      if (!ctrl_q[0]) begin
         state_d  = IDLE;
         cnt_d    = '0;
         pulses_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d    = '0;
               pulses_d = '0;
               state_d  = RUN;
            end
            RUN: begin
               if (wrap) begin
                  cnt_d    = '0;
                  pulses_d = (pulses_q == '1) ? pulses_q : pulses_q + CntWidth'(1);
                  if (count_q != '0 && pulses_nxt >= {1'b0, count_q}) begin
                     state_d  = DONE;
                     done_set = 1'b1;
                     if (ctrl_q[1]) ctrl_d[0] = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CntWidth'(1);
               end
            end
            default: cnt_d = '0;
         endcase
      end

      done_d  = (done_q & ~done_clr) | done_set;
      pulse_d = ((state_q == RUN) && (cnt_q < high_q)) ^ ctrl_q[2];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ctrl_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         count_q  <= '0;
         cnt_q    <= '0;
         pulses_q <= '0;
         done_q   <= 1'b0;
         pulse_q  <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         high_q   <= high_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
         pulses_q <= pulses_d;
         done_q   <= done_d;
         pulse_q  <= pulse_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         rid_q    <= rid_d;
      end
   end

   always_comb begin
      obi_rsp_o              = '0;
      obi_rsp_o.gnt          = obi_req_i.req;
      obi_rsp_o.rvalid       = rvalid_q;
      obi_rsp_o.r.rdata      = rdata_q;
      obi_rsp_o.r.rid        = rid_q;
      obi_rsp_o.r.err        = err_q;
      obi_rsp_o.r.r_optional = 1'b0;
   end

   assign pulse_o = pulse_q;
`ifdef OBI_PULSER_IRQ_EN
   assign irq_o = done_q;
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_pulser.sv
// Directed + randomized bench for obi_pulser; pulse/irq expectations come from an arithmetic burst model.
module tb_obi_pulser;
   import obi_pulser_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   sbr_obi_req_t req;
   sbr_obi_rsp_t rsp;
   logic         pulse, irq;
   int           npass = 0, ntot = 0;
   logic [31:0]  r_rdata;
   logic         r_err;

`ifdef OBI_PULSER_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   obi_pulser #(.CntWidth(32)) dut (
      .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_rsp_o(rsp),
      .pulse_o(pulse), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge after the response cycle.
   task automatic bus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
      logic [3:0] aid;
      aid         = 4'($urandom);
      req.a.addr  = {20'h0300C, addr};
      req.a.we    = we;
      req.a.be    = be;
      req.a.wdata = wdata;
      req.a.aid   = aid;
      req.req     = 1'b1;
      #1 check("gnt", rsp.gnt, 1);
      @(posedge clk);
      @(negedge clk);
      req.req  = 1'b0;
      req.a.we = 1'b0;
      check("rvalid", rsp.rvalid, 1);
      check("rid", rsp.r.rid, aid);
      r_rdata = rsp.r.rdata;
      r_err   = rsp.r.err;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      bus(1'b1, addr, data, 4'hF);
      check("wr_err", r_err, 0);
   endtask

   task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
      bus(1'b0, addr, 32'h0, 4'hF);
      check(tag, r_rdata, exp);
      check({tag, "_err"}, r_err, 0);
   endtask

   // Reference: sample k after enable shows ((k mod P) < H) while k < P*C, idle otherwise, XOR INV.
   task automatic run_burst(input int p, input int h, input int c, input bit inv, input bit oneshot);
      int   pe, len;
      logic exp_p;
      pe  = (p == 0) ? 1 : p;
      len = (c == 0) ? 3 * pe + 4 : pe * c;
      wr(12'h004, 32'(p));
      wr(12'h008, 32'(h));
      wr(12'h00C, 32'(c));
      wr(12'h000, {29'b0, inv, oneshot, 1'b1});
      @(negedge clk);
      for (int k = 0; k < len + 3; k++) begin
         @(negedge clk);
         exp_p = ((c == 0 || k < pe * c) && (k % pe) < h) ^ inv;
         check("pulse", pulse, exp_p);
         check("irq", irq, IrqEn && c != 0 && k >= pe * c - 1);
      end
      if (c != 0) begin
         rd(12'h010, 32'h2, "status_done");
         rd(12'h000, oneshot ? {29'b0, inv, 2'b10} : {29'b0, inv, 2'b01}, "ctrl_after");
         wr(12'h000, 32'h0);
         wr(12'h010, 32'h2);
         check("irq_clr", irq, 0);
         rd(12'h010, 32'h0, "status_clr");
      end
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      repeat (3) @(negedge clk);
      check("rst_pulse", pulse, 0);
      check("rst_irq", irq, 0);
      check("rst_rvalid", rsp.rvalid, 0);
      check("rst_rdata", rsp.r.rdata, 0);
      check("rst_err", rsp.r.err, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int a = 0; a < 6; a++) rd(12'(a * 4), 32'h0, "reset_reg");

      wr(12'h004, 32'h0);
      bus(1'b1, 12'h004, 32'hAABBCCDD, 4'b0101);
      rd(12'h004, 32'h00BB00DD, "be_merge");
      bus(1'b0, 12'h040, 32'h0, 4'hF);
      check("bad_err", r_err, 1);
      check("bad_rdata", r_rdata, 0);

      run_burst(4, 1, 3, 1'b0, 1'b0);

      run_burst(5, 2, 0, 1'b1, 1'b0);
      wr(12'h000, 32'h4);
      @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         check("inv_idle", pulse, 1);
      end
      rd(12'h014, 32'h0, "cnt_idle");
      rd(12'h010, 32'h0, "status_idle");
      wr(12'h000, 32'h0);

      run_burst(3, 1, 2, 1'b0, 1'b1);
      run_burst(4, 0, 2, 1'b0, 1'b0);
      run_burst(4, 8, 1, 1'b0, 1'b0);
      run_burst(0, 1, 3, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++)
         run_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
                   int'($urandom_range(1, 3)), 1'($urandom), 1'($urandom));

      // Reset landing on the grant edge drops the pending response.
      req.a.addr = 32'h0300C000;
      req.a.we   = 1'b0;
      req.req    = 1'b1;
      rst        = 1'b1;
      @(negedge clk);
      req.req = 1'b0;
      rst     = 1'b0;
      check("rst_drop_rvalid", rsp.rvalid, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
